mpu_reg_write_arbiter: RTL and testbench

//  Shares the matrix register-file write port between NREQ matrix writers (load unit, multiply write-back, ...).

---
 rtl/mpu_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/mpu_reg_write_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mpu_reg_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared types and matrix geometry for the MPU register-file write path.
// Pure declarations; no timing or flow control.
package mpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

  localparam int ARB_MAX_NREQ    = 8;
  localparam int MATRIX_REG_BITS = 2;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int FPBITS          = 31;

  localparam logic [MBITS:0] MAX_M = (MBITS + 1)'(4);
  localparam logic [NBITS:0] MAX_N = (NBITS + 1)'(4);

  // A burst must describe a non-empty matrix that fits the register file.
  function automatic logic dims_bad(input logic [MBITS:0] m, input logic [NBITS:0] n);
    return (m == '0) || (n == '0) || (m > MAX_M) || (n > MAX_N);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first asserted request strictly after i_last, wrapping.
// Combinational, zero latency; no flow control.
module rr_priority_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(i_last) + k) % NREQ);
      if (!o_vld && i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/mpu_reg_write_arbiter.sv
// Matrix-granular round-robin owner of the register-file write port; beats forwarded with 1-cycle latency.
// Writers hold req for a whole m x n burst; non-owners are simply not granted (no beat is dropped for the owner).
module mpu_reg_write_arbiter
  import mpu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREQ-1:0]                    req_in,
  output logic [NREQ-1:0]                    grant_out,
  input  logic [NREQ-1:0]                    wr_en_in,
  input  logic [NREQ-1:0][MATRIX_REG_BITS:0] addr_in,
  input  logic [NREQ-1:0][MBITS:0]           m_size_in,
  input  logic [NREQ-1:0][NBITS:0]           n_size_in,
  input  logic [NREQ-1:0][FPBITS:0]          element_in,
  input  logic [NREQ-1:0][MBITS:0]           i_loc_in,
  input  logic [NREQ-1:0][NBITS:0]           j_loc_in,
  output logic                               reg_load_en_out,
  output logic [MATRIX_REG_BITS:0]           reg_load_addr_out,
  output logic [FPBITS:0]                    reg_load_element_out,
  output logic [MBITS:0]                     reg_i_load_loc_out,
  output logic [NBITS:0]                     reg_j_load_loc_out,
  output logic [MBITS:0]                     reg_m_load_size_out,
  output logic [NBITS:0]                     reg_n_load_size_out,
  output logic                               busy_out,
  output logic [NREQ-1:0]                    dim_error_out,
  output logic                               timeout_error_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = MBITS + NBITS + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t r_state, w_state_nxt;

  logic [IW-1:0]            r_rr_ptr;
  logic [NREQ-1:0]          r_grant;
  logic                     r_busy;
  logic [MATRIX_REG_BITS:0] r_addr;
  logic [MBITS:0]           r_m;
  logic [NBITS:0]           r_n;
  logic [PW-1:0]            r_total;
  logic [PW-1:0]            r_beat_cnt;
  logic [TW-1:0]            r_idle_cnt;
  logic                     r_load_en;
  logic [FPBITS:0]          r_elem;
  logic [MBITS:0]           r_i;
  logic [NBITS:0]           r_j;
  logic [NREQ-1:0]          r_dim_err;
  logic                     r_to_err;

  logic [IW-1:0] w_pick_idx;
  logic          w_pick_vld;
  logic          w_pick_bad;
  logic          w_grant_start;
  logic          w_reject;
  logic          w_beat;
  logic          w_timeout;
  logic [MBITS:0] w_pick_m;
  logic [NBITS:0] w_pick_n;

  rr_priority_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req  (req_in),
    .i_last (r_rr_ptr),
    .o_idx  (w_pick_idx),
    .o_vld  (w_pick_vld)
  );

  assign w_pick_m   = m_size_in[w_pick_idx];
  assign w_pick_n   = n_size_in[w_pick_idx];
  assign w_pick_bad = dims_bad(w_pick_m, w_pick_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_start = 1'b0;
    w_reject      = 1'b0;
    w_beat        = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_vld) begin
          if (w_pick_bad) begin
            w_reject = 1'b1;
          end else begin
            w_grant_start = 1'b1;
            w_state_nxt   = ARB_GRANT;
          end
        end
      end
      ARB_GRANT: begin
        w_beat = wr_en_in[r_rr_ptr];
        // A final beat wins over a simultaneous req drop: it is a normal completion.
        if (w_beat && ((r_beat_cnt + PW'(1)) == r_total)) begin
          w_state_nxt = ARB_RELEASE;
        end else if (!req_in[r_rr_ptr]) begin
          w_state_nxt = ARB_RELEASE;
        end else if (!w_beat && ((r_idle_cnt + TW'(1)) == TW'(TIMEOUT))) begin
          w_timeout   = 1'b1;
          w_state_nxt = ARB_RELEASE;
        end
      end
      ARB_RELEASE: w_state_nxt = ARB_IDLE;
      default:     w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= IW'(NREQ - 1);
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_total    <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      r_load_en  <= 1'b0;
      r_elem     <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_dim_err  <= '0;
      r_to_err   <= 1'b0;
    end else begin
      r_dim_err <= '0;
      r_load_en <= w_beat;
      r_elem    <= w_beat ? element_in[r_rr_ptr] : '0;
      r_i       <= w_beat ? i_loc_in[r_rr_ptr]   : '0;
      r_j       <= w_beat ? j_loc_in[r_rr_ptr]   : '0;

      if (w_reject) begin
        r_dim_err[w_pick_idx] <= 1'b1;
        r_rr_ptr              <= w_pick_idx;
      end

      if (w_grant_start) begin
        r_grant             <= '0;
        r_grant[w_pick_idx] <= 1'b1;
        r_busy              <= 1'b1;
        r_rr_ptr            <= w_pick_idx;
        r_addr              <= addr_in[w_pick_idx];
        r_m                 <= w_pick_m;
        r_n                 <= w_pick_n;
        r_total             <= PW'(w_pick_m) * PW'(w_pick_n);
        r_beat_cnt          <= '0;
        r_idle_cnt          <= '0;
        r_to_err            <= 1'b0;
      end

      if (r_state == ARB_GRANT) begin
        if (w_beat) begin
          r_beat_cnt <= r_beat_cnt + PW'(1);
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + TW'(1);
        end
        if (w_state_nxt == ARB_RELEASE) begin
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      end

      if (w_timeout) r_to_err <= 1'b1;

      // Address/sizes survive into RELEASE so the final beat still carries them.
      if (r_state == ARB_RELEASE) begin
        r_addr  <= '0;
        r_m     <= '0;
        r_n     <= '0;
        r_total <= '0;
      end
    end
  end

  assign grant_out            = r_grant;
  assign busy_out             = r_busy;
  assign reg_load_en_out      = r_load_en;
  assign reg_load_element_out = r_elem;
  assign reg_i_load_loc_out   = r_i;
  assign reg_j_load_loc_out   = r_j;
  assign reg_load_addr_out    = (r_busy || r_load_en) ? r_addr : '0;
  assign reg_m_load_size_out  = (r_busy || r_load_en) ? r_m : '0;
  assign reg_n_load_size_out  = (r_busy || r_load_en) ? r_n : '0;
  assign dim_error_out        = r_dim_err;
  assign timeout_error_out    = r_to_err;

endmodule

// File: tb/tb_mpu_reg_write_arbiter.sv
// Scenario bench for mpu_reg_write_arbiter: expected beats queued at drive time, popped on each strobe.
module tb_mpu_reg_write_arbiter;
  import mpu_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;
  localparam int AW = MATRIX_REG_BITS + 1;
  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;
  localparam int EW = FPBITS + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [EW-1:0] elem;
    logic [MW-1:0] i;
    logic [NW-1:0] j;
  } beat_t;

  beat_t sb[$];
  beat_t mon_got, mon_exp;
  int errors = 0;
  int checks = 0;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NREQ-1:0]          req_in = '0;
  logic [NREQ-1:0]          grant_out;
  logic [NREQ-1:0]          wr_en_in = '0;
  logic [NREQ-1:0][AW-1:0]  addr_in = '0;
  logic [NREQ-1:0][MW-1:0]  m_size_in = '0;
  logic [NREQ-1:0][NW-1:0]  n_size_in = '0;
  logic [NREQ-1:0][EW-1:0]  element_in = '0;
  logic [NREQ-1:0][MW-1:0]  i_loc_in = '0;
  logic [NREQ-1:0][NW-1:0]  j_loc_in = '0;
  logic                     reg_load_en_out;
  logic [AW-1:0]            reg_load_addr_out;
  logic [EW-1:0]            reg_load_element_out;
  logic [MW-1:0]            reg_i_load_loc_out;
  logic [NW-1:0]            reg_j_load_loc_out;
  logic [MW-1:0]            reg_m_load_size_out;
  logic [NW-1:0]            reg_n_load_size_out;
  logic                     busy_out;
  logic [NREQ-1:0]          dim_error_out;
  logic                     timeout_error_out;

  mpu_reg_write_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_in               (req_in),
    .grant_out            (grant_out),
    .wr_en_in             (wr_en_in),
    .addr_in              (addr_in),
    .m_size_in            (m_size_in),
    .n_size_in            (n_size_in),
    .element_in           (element_in),
    .i_loc_in             (i_loc_in),
    .j_loc_in             (j_loc_in),
    .reg_load_en_out      (reg_load_en_out),
    .reg_load_addr_out    (reg_load_addr_out),
    .reg_load_element_out (reg_load_element_out),
    .reg_i_load_loc_out   (reg_i_load_loc_out),
    .reg_j_load_loc_out   (reg_j_load_loc_out),
    .reg_m_load_size_out  (reg_m_load_size_out),
    .reg_n_load_size_out  (reg_n_load_size_out),
    .busy_out             (busy_out),
    .dim_error_out        (dim_error_out),
    .timeout_error_out    (timeout_error_out)
  );

  always #5 clk = ~clk;

  // Every strobe must match the oldest queued beat exactly.
  always @(negedge clk) begin
    if (!rst && reg_load_en_out) begin
      mon_got = {reg_load_addr_out, reg_load_element_out, reg_i_load_loc_out, reg_j_load_loc_out};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got addr=%0d elem=%h i=%0d j=%0d, required no strobe",
                 mon_got.addr, mon_got.elem, mon_got.i, mon_got.j);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL strobe_data: got addr=%0d elem=%h i=%0d j=%0d, required addr=%0d elem=%h i=%0d j=%0d",
                   mon_got.addr, mon_got.elem, mon_got.i, mon_got.j,
                   mon_exp.addr, mon_exp.elem, mon_exp.i, mon_exp.j);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    req_in = '0; wr_en_in = '0; addr_in = '0; m_size_in = '0; n_size_in = '0;
    element_in = '0; i_loc_in = '0; j_loc_in = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] eg, output int w);
    w = 0;
    while (grant_out !== eg && w < 100) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic do_burst(input int r, input int m, input int n, input logic [AW-1:0] a,
                          input int exp_wait, input bit drop, input bit intrude);
    int w;
    beat_t e;
    logic [NREQ-1:0] eg;
    eg = '0;
    eg[r] = 1'b1;
    req_in[r] = 1'b1; m_size_in[r] = MW'(m); n_size_in[r] = NW'(n); addr_in[r] = a;
    wait_grant(eg, w);
    checks++;
    if (grant_out !== eg || w != exp_wait || busy_out !== 1'b1 || reg_load_addr_out !== a ||
        reg_m_load_size_out !== MW'(m) || reg_n_load_size_out !== NW'(n) || timeout_error_out !== 1'b0) begin
      errors++;
      $display("FAIL grant_r%0d: got grant=%b wait=%0d busy=%b addr=%0d m=%0d n=%0d to=%b, required grant=%b wait=%0d busy=1 addr=%0d m=%0d n=%0d to=0",
               r, grant_out, w, busy_out, reg_load_addr_out, reg_m_load_size_out, reg_n_load_size_out,
               timeout_error_out, eg, exp_wait, a, m, n);
    end
    for (int b = 0; b < m * n; b++) begin
      e.addr = a; e.elem = $urandom; e.i = MW'(b / n); e.j = NW'(b % n);
      wr_en_in[r] = 1'b1; element_in[r] = e.elem; i_loc_in[r] = e.i; j_loc_in[r] = e.j;
      sb.push_back(e);
      if (intrude) begin
        wr_en_in[1-r] = 1'b1; element_in[1-r] = $urandom;
        i_loc_in[1-r] = MW'($urandom_range(0, 3)); j_loc_in[1-r] = NW'($urandom_range(0, 3));
      end
      @(negedge clk);
      checks++;
      if (reg_load_en_out !== 1'b1 || reg_i_load_loc_out !== e.i || reg_j_load_loc_out !== e.j) begin
        errors++;
        $display("FAIL beat_latency r%0d b%0d: got en=%b i=%0d j=%0d, required en=1 i=%0d j=%0d",
                 r, b, reg_load_en_out, reg_i_load_loc_out, reg_j_load_loc_out, e.i, e.j);
      end
    end
    wr_en_in = '0;
    if (drop) req_in[r] = 1'b0;
    checks++;
    if (grant_out !== '0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL release_r%0d: got grant=%b busy=%b, required grant=00 busy=0", r, grant_out, busy_out);
    end
    @(negedge clk);
    checks++;
    if (grant_out !== '0 || reg_load_en_out !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL dead_cycle_r%0d: got grant=%b en=%b pending=%0d, required grant=00 en=0 pending=0",
               r, grant_out, reg_load_en_out, sb.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({grant_out, busy_out, reg_load_en_out, reg_load_addr_out, reg_load_element_out, reg_i_load_loc_out,
         reg_j_load_loc_out, reg_m_load_size_out, reg_n_load_size_out, dim_error_out, timeout_error_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b busy=%b en=%b addr=%0d elem=%h dim=%b to=%b, required all 0",
               grant_out, busy_out, reg_load_en_out, reg_load_addr_out, reg_load_element_out,
               dim_error_out, timeout_error_out);
    end
  endtask

  task automatic test_single();
    do_burst(0, 2, 2, AW'(5), 1, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_in[1] = 1'b1; m_size_in[1] = MW'(3); n_size_in[1] = NW'(3); addr_in[1] = AW'(2);
    do_burst(0, 3, 3, AW'(1), 1, 1'b0, 1'b0);
    do_burst(1, 3, 3, AW'(2), 1, 1'b0, 1'b0);
    do_burst(0, 3, 3, AW'(1), 1, 1'b1, 1'b0);
    do_burst(1, 1, 1, AW'(2), 1, 1'b1, 1'b0);
  endtask

  task automatic test_dim_error();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      req_in[0] = 1'b1; addr_in[0] = AW'(1);
      m_size_in[0] = (c == 0) ? MW'(0) : MW'(2);
      n_size_in[0] = (c == 0) ? NW'(2) : (MAX_N + NW'(1));
      req_in[1] = 1'b1; m_size_in[1] = MW'(2); n_size_in[1] = NW'(2); addr_in[1] = AW'(6);
      @(negedge clk);
      checks++;
      if (dim_error_out !== 2'b01 || grant_out !== 2'b00) begin
        errors++;
        $display("FAIL dim_pulse c%0d: got dim=%b grant=%b, required dim=01 grant=00", c, dim_error_out, grant_out);
      end
      req_in[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (dim_error_out !== 2'b00 || grant_out !== 2'b10) begin
        errors++;
        $display("FAIL dim_after c%0d: got dim=%b grant=%b, required dim=00 grant=10", c, dim_error_out, grant_out);
      end
      do_burst(1, 2, 2, AW'(6), 0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_timeout();
    int w;
    int n;
    req_in[0] = 1'b1; m_size_in[0] = MW'(2); n_size_in[0] = NW'(2); addr_in[0] = AW'(3);
    wait_grant(2'b01, w);
    n = 0;
    while (grant_out[0] === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TIMEOUT || timeout_error_out !== 1'b1 || busy_out !== 1'b0 || reg_load_en_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: got cycles=%0d to=%b busy=%b en=%b, required cycles=%0d to=1 busy=0 en=0",
               n, timeout_error_out, busy_out, reg_load_en_out, TIMEOUT);
    end
    req_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_error_out !== 1'b1 || grant_out !== 2'b00) begin
      errors++;
      $display("FAIL timeout_sticky: got to=%b grant=%b, required to=1 grant=00", timeout_error_out, grant_out);
    end
    do_burst(1, 1, 1, AW'(2), 1, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_other();
    do_burst(0, 2, 2, AW'(4), 1, 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    int w;
    beat_t e;
    req_in[0] = 1'b1; m_size_in[0] = MW'(2); n_size_in[0] = NW'(2); addr_in[0] = AW'(7);
    wait_grant(2'b01, w);
    for (int b = 0; b < 2; b++) begin
      e.addr = AW'(7); e.elem = $urandom; e.i = MW'(b / 2); e.j = NW'(b % 2);
      wr_en_in[0] = 1'b1; element_in[0] = e.elem; i_loc_in[0] = e.i; j_loc_in[0] = e.j;
      sb.push_back(e);
      @(negedge clk);
    end
    element_in[0] = 32'hDEAD_BEEF; i_loc_in[0] = MW'(1); j_loc_in[0] = NW'(0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grant_out, busy_out, reg_load_en_out, reg_load_addr_out, reg_load_element_out,
         reg_i_load_loc_out, reg_j_load_loc_out, timeout_error_out} !== '0) begin
      errors++;
      $display("FAIL async_reset: got grant=%b busy=%b en=%b addr=%0d elem=%h, required all 0",
               grant_out, busy_out, reg_load_en_out, reg_load_addr_out, reg_load_element_out);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (reg_load_en_out !== 1'b0 || grant_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: got en=%b grant=%b, required en=0 grant=00", reg_load_en_out, grant_out);
    end
    clear_inputs();
    sb.delete();
    req_in = 2'b11;
    m_size_in[0] = MW'(2); n_size_in[0] = NW'(2); addr_in[0] = AW'(3);
    m_size_in[1] = MW'(2); n_size_in[1] = NW'(2); addr_in[1] = AW'(5);
    rst = 1'b0;
    wait_grant(2'b01, w);
    checks++;
    if (grant_out !== 2'b01 || w != 1) begin
      errors++;
      $display("FAIL post_reset_first: got grant=%b wait=%0d, required grant=01 wait=1", grant_out, w);
    end
    req_in[1] = 1'b0;
    do_burst(0, 2, 2, AW'(3), 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dim_error();
    test_timeout();
    test_ignore_other();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
